// File: rtl/tmr_sram_scrub.sv
// rtl/tmr_sram_scrub.sv - triple-redundant SRAM with bitwise voting, read error flags and idle-time scrubber
// User access always has priority; the scrubber only writes back words with a 2-of-3 word majority.
module tmr_sram_scrub #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 16,
  parameter bit SCRUB_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data_in,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_rd_valid,
  output logic              o_err_corr,
  output logic              o_err_uncorr,
  input  logic              i_scrub_en,
  output logic              o_scrub_busy,
  output logic              o_scrub_done,
  output logic [CNT_W-1:0]  o_fix_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] SP_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CHECK, S_WB} state_t;

  logic [DATA_W-1:0] r_mem_a [0:DEPTH-1];
  logic [DATA_W-1:0] r_mem_b [0:DEPTH-1];
  logic [DATA_W-1:0] r_mem_c [0:DEPTH-1];

  state_t            r_state;
  logic [ADDR_W-1:0] r_sp;
  logic [DATA_W-1:0] r_sa, r_sb, r_sc;
  logic [CNT_W-1:0]  r_fix_cnt;
  logic              r_done;
  logic [DATA_W-1:0] r_data_out;
  logic              r_rd_valid, r_err_corr, r_err_uncorr;

  logic [DATA_W-1:0] w_ua, w_ub, w_uc, w_u_vote, w_s_vote;
  logic              w_u_all_eq, w_u_uncorr, w_s_all_eq, w_s_uncorr;
  logic              w_user_rd, w_user_wr, w_scrub_wr, w_sp_last;

  function automatic logic [DATA_W-1:0] f_vote(input logic [DATA_W-1:0] a, b, c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign w_ua       = r_mem_a[i_addr];
  assign w_ub       = r_mem_b[i_addr];
  assign w_uc       = r_mem_c[i_addr];
  assign w_u_vote   = f_vote(w_ua, w_ub, w_uc);
  assign w_u_all_eq = (w_ua == w_ub) && (w_ub == w_uc);
  assign w_u_uncorr = (w_ua != w_ub) && (w_ua != w_uc) && (w_ub != w_uc);

  assign w_s_vote   = f_vote(r_sa, r_sb, r_sc);
  assign w_s_all_eq = (r_sa == r_sb) && (r_sb == r_sc);
  assign w_s_uncorr = (r_sa != r_sb) && (r_sa != r_sc) && (r_sb != r_sc);

  assign w_user_rd  = i_enable && !i_we;
  assign w_user_wr  = i_enable && i_we;
  // A user access or reset in the WB cycle cancels the write-back.
  assign w_scrub_wr = (r_state == S_WB) && !i_enable && !i_rst;
  assign w_sp_last  = (r_sp == '1);

  always_ff @(posedge i_clk) begin
    if (w_user_wr) begin
      r_mem_a[i_addr] <= i_data_in;
      r_mem_b[i_addr] <= i_data_in;
      r_mem_c[i_addr] <= i_data_in;
    end else if (w_scrub_wr) begin
      r_mem_a[r_sp] <= w_s_vote;
      r_mem_b[r_sp] <= w_s_vote;
      r_mem_c[r_sp] <= w_s_vote;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data_out   <= '0;
      r_rd_valid   <= 1'b0;
      r_err_corr   <= 1'b0;
      r_err_uncorr <= 1'b0;
    end else begin
      r_rd_valid   <= w_user_rd;
      r_err_corr   <= w_user_rd && !w_u_all_eq && !w_u_uncorr;
      r_err_uncorr <= w_user_rd && w_u_uncorr;
      if (w_user_rd) r_data_out <= w_u_vote;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_sp      <= '0;
      r_sa      <= '0;
      r_sb      <= '0;
      r_sc      <= '0;
      r_fix_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (SCRUB_EN && i_scrub_en && !i_enable) r_state <= S_READ;
        end
        S_READ: begin
          if (i_enable) begin
            r_state <= S_IDLE;
          end else begin
            r_sa    <= r_mem_a[r_sp];
            r_sb    <= r_mem_b[r_sp];
            r_sc    <= r_mem_c[r_sp];
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (i_enable) begin
            r_state <= S_IDLE;
          end else if (w_s_all_eq || w_s_uncorr) begin
            r_sp    <= r_sp + SP_ONE;
            r_done  <= w_sp_last;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WB;
          end
        end
        S_WB: begin
          if (!i_enable) begin
            if (r_fix_cnt != '1) r_fix_cnt <= r_fix_cnt + CNT_ONE;
            r_sp   <= r_sp + SP_ONE;
            r_done <= w_sp_last;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_data_out   = r_data_out;
  assign o_rd_valid   = r_rd_valid;
  assign o_err_corr   = r_err_corr;
  assign o_err_uncorr = r_err_uncorr;
  assign o_scrub_busy = (r_state != S_IDLE);
  assign o_scrub_done = r_done;
  assign o_fix_cnt    = r_fix_cnt;

endmodule

// File: tb/tb_tmr_sram_scrub.sv
// tb/tb_tmr_sram_scrub.sv - directed bench for tmr_sram_scrub (32 words, 2-bit repair counter)
module tb_tmr_sram_scrub;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst, enable, we, scrub_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          rd_valid, err_corr, err_uncorr, busy, done;
  logic [CW-1:0] fix_cnt;

  int checks = 0;
  int errors = 0;
  int n;
  bit got;
  int ws [5] = '{8, 9, 11, 12, 13};

  always #5 clk = ~clk;

  tmr_sram_scrub #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .SCRUB_EN(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_we(we), .i_addr(addr),
    .i_data_in(din), .o_data_out(dout), .o_rd_valid(rd_valid), .o_err_corr(err_corr),
    .o_err_uncorr(err_uncorr), .i_scrub_en(scrub_en), .o_scrub_busy(busy),
    .o_scrub_done(done), .o_fix_cnt(fix_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    enable = 1'b1; we = 1'b1; addr = a; din = d;
    tick();
    enable = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic c, input logic u);
    enable = 1'b1; we = 1'b0; addr = a;
    tick();
    enable = 1'b0;
    chk({tag, "_data"}, 32'(dout), 32'(d));
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_corr"}, 32'(err_corr), 32'(c));
    chk({tag, "_uncorr"}, 32'(err_uncorr), 32'(u));
  endtask

  task automatic wait_done(input string tag);
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      tick();
      n++;
      got = done;
    end
    chk({tag, "_seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; we = 1'b0; scrub_en = 1'b0; addr = '0; din = '0;
    tick();
    tick();
    chk("rst_data", 32'(dout), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_corr", 32'(err_corr), 32'd0);
    chk("rst_uncorr", 32'(err_uncorr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fix", 32'(fix_cnt), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) wr(AW'(i), DW'(i) ^ 8'h5A);
    wr(5'd10, 8'h2C);
    wr(5'd20, 8'h3C);
    wr(5'd30, 8'hA5);

    rd_chk("rd10", 5'd10, 8'h2C, 1'b0, 1'b0);
    rd_chk("rd20", 5'd20, 8'h3C, 1'b0, 1'b0);
    rd_chk("rd30", 5'd30, 8'hA5, 1'b0, 1'b0);
    tick();
    chk("idle_valid", 32'(rd_valid), 32'd0);
    chk("idle_hold", 32'(dout), 32'hA5);

    dut.r_mem_a[10] = 8'h00;
    rd_chk("corr10", 5'd10, 8'h2C, 1'b1, 1'b0);
    tick();
    chk("corr10_no_wb", 32'(dut.r_mem_a[10]), 32'h00);

    dut.r_mem_a[20] = 8'hAA;
    dut.r_mem_b[20] = 8'hBB;
    dut.r_mem_c[20] = 8'hCC;
    rd_chk("uncorr20", 5'd20, 8'hAA, 1'b0, 1'b1);
    wr(5'd10, 8'h2C);
    wr(5'd20, 8'h3C);

    // Full sweeps: one repair in the first, clean words take exactly 3 cycles each.
    dut.r_mem_c[5] = 8'h11;
    scrub_en = 1'b1;
    tick();
    chk("scrub_busy", 32'(busy), 32'd1);
    wait_done("sweep1");
    chk("sweep1_fix", 32'(fix_cnt), 32'd1);
    chk("sweep1_mem_c5", 32'(dut.r_mem_c[5]), 32'h5F);
    tick();
    chk("done_pulse_width", 32'(done), 32'd0);
    wait_done("sweep2");
    chk("sweep_period", 32'(n + 1), 32'd96);
    chk("sweep2_fix", 32'(fix_cnt), 32'd1);
    scrub_en = 1'b0;
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_fix", 32'(fix_cnt), 32'd0);
    dut.r_mem_b[3] = 8'h00;
    scrub_en = 1'b1;
    repeat (12) tick();
    chk("wb_busy", 32'(busy), 32'd1);
    chk("wb_sp", 32'(dut.r_sp), 32'd3);
    enable = 1'b1; we = 1'b0; addr = 5'd7;
    tick();
    enable = 1'b0;
    chk("abort_rd_data", 32'(dout), 32'h5D);
    chk("abort_rd_valid", 32'(rd_valid), 32'd1);
    chk("abort_no_wb", 32'(dut.r_mem_b[3]), 32'h00);
    chk("abort_sp", 32'(dut.r_sp), 32'd3);
    chk("abort_fix", 32'(fix_cnt), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    repeat (4) tick();
    scrub_en = 1'b0;
    chk("retry_mem_b3", 32'(dut.r_mem_b[3]), 32'h59);
    chk("retry_fix", 32'(fix_cnt), 32'd1);
    chk("retry_sp", 32'(dut.r_sp), 32'd4);

    for (int k = 0; k < 5; k++) dut.r_mem_a[ws[k]] = ~(DW'(ws[k]) ^ 8'h5A);
    scrub_en = 1'b1;
    wait_done("sweep_sat");
    chk("sat_fix", 32'(fix_cnt), 32'd3);
    chk("sat_mem_a13", 32'(dut.r_mem_a[13]), 32'h57);

    dut.r_mem_c[2] = 8'hFF;
    repeat (8) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_data", 32'(dout), 32'd0);
    chk("midrst_valid", 32'(rd_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_fix", 32'(fix_cnt), 32'd0);
    chk("midrst_sp", 32'(dut.r_sp), 32'd0);
    chk("midrst_no_wb", 32'(dut.r_mem_c[2]), 32'hFF);
    rst = 1'b0;
    scrub_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tmr_sram_scrub.md
# tmr_sram_scrub

Triple-modular-redundant synchronous SRAM with bitwise majority voting, per-read error classification and a background scrubber that repairs single-copy upsets during idle cycles. It is the parametrised successor of the fixed 256x8 TMR memory top: it keeps the same access port (enable/we/addr/data_in/data_out) and adds configurable width and depth, error reporting and autonomous write-back correction. It sits directly behind the user datapath as a drop-in radiation-hardened storage block.

## Interface
- ADDR_W, 8, address width; depth = 2^ADDR_W words
- DATA_W, 8, word width in bits
- CNT_W, 16, width of the saturating repair counter
- SCRUB_EN, 1, 0 removes the scrubber entirely (scrub_en ignored, scrub outputs tied 0)

Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- enable  in  1  user access request, sampled each cycle
- we  in  1  1 = write, 0 = read (valid with enable)
- addr  in  ADDR_W  user address
- data_in  in  DATA_W  write data
- data_out  out  DATA_W  voted read data, registered
- rd_valid  out  1  one-cycle pulse, data_out valid
- err_corr  out  1  with rd_valid: copies disagreed, a word-level 2-of-3 majority existed
- err_uncorr  out  1  with rd_valid: all three copies pairwise different
- scrub_en  in  1  allow background scrubbing
- scrub_busy  out  1  scrubber in a non-IDLE state
- scrub_done  out  1  one-cycle pulse when scrub pointer wraps from 2^ADDR_W-1 to 0
- fix_cnt  out  CNT_W  number of scrub write-backs, saturates at all-ones

## Operation
- Three identical arrays mem_a/mem_b/mem_c, DATA_W x 2^ADDR_W; contents not cleared by rst.
- User write (enable=1, we=1): data_in written to all three copies at addr in the same edge.
- User read (enable=1, we=0): three copies read, bitwise majority v = (a&b)|(a&c)|(b&c) registered to data_out. err_corr = copies not all equal and at least two equal; err_uncorr = a!=b, a!=c, b!=c. data_out always carries v, even when uncorrectable.
- User reads never write back; repair is the scrubber's job.
- Scrubber FSM (states IDLE, READ, CHECK, WB), pointer sp (ADDR_W bits):
  - IDLE -> READ when scrub_en=1 and enable=0.
  - READ: latch three copies at sp -> CHECK.
  - CHECK: if all equal or uncorrectable, advance sp -> IDLE; else -> WB.
  - WB: write v to all three copies at sp, fix_cnt += 1 (saturating), advance sp -> IDLE.
  - enable=1 in READ, CHECK or WB: abort to IDLE on that edge, no write-back, sp not advanced (word rescanned later). User access always wins.
- sp advance wraps 2^ADDR_W-1 -> 0 and pulses scrub_done on that edge.
- scrub_en deasserted mid-scrub: current step completes, then IDLE; no new scrub starts.

## Timing
- Reset values: data_out=0, rd_valid=0, err_corr=0, err_uncorr=0, scrub_busy=0, scrub_done=0, fix_cnt=0, sp=0, FSM=IDLE.
- Write: memory updated at the edge sampling enable=1, we=1; read of same addr next cycle returns new data.
- Read latency 1: request sampled at edge N, data_out/rd_valid/err_* valid after edge N, held until next read; rd_valid and err_* are 0 in non-read cycles.
- Back-to-back reads: one result per cycle.
- Scrub of one clean word: 3 cycles (IDLE->READ->CHECK->IDLE); repaired word: 4 cycles.
- rst asserted mid-scrub: FSM to IDLE, sp=0, no write-back on that edge.
- Scrubber write and user access never occur in the same cycle.

## Test plan
- Reset, write addr10=0x2C, 20=0x3C, 30=0xA5, read back -> data_out 0x2C/0x3C/0xA5 one cycle after each request, err_corr=err_uncorr=0.
- Force mem_a[10]=0x00, read 10 (scrub_en=0) -> data_out=0x2C, err_corr=1, err_uncorr=0; mem_a[10] stays 0x00.
- Force mem_a[20]=0xAA, mem_b[20]=0xBB, mem_c[20]=0xCC, read 20 -> data_out=0xAA (bitwise vote), err_uncorr=1, err_corr=0.
- ADDR_W=4: corrupt mem_c[5]=0x11, scrub_en=1, enable=0 for a full sweep -> mem_c[5] restored, fix_cnt=1, scrub_done pulses once per 16 words.
- Corrupt mem_b[3], assert enable read during scrubber WB at sp=3 -> user read served, no write-back that cycle, sp stays 3, repair completes on next idle slot, fix_cnt increments once.
- Set fix_cnt near all-ones (CNT_W=2), repair 5 words -> fix_cnt saturates at 3; rst mid-scrub -> all outputs return to reset values.
